// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word reads to instruction memory and keeps a
// two-entry buffer of {PC, instruction} pairs for decode. Branch redirects flush
// the buffer. A read that is still in flight when a redirect arrives is squashed.
module fetch_unit #(
  parameter logic [23:0] RESET_PC  = 24'h000000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic        MemReq,
  output logic [23:0] MemAddr,
  input  logic        MemAck,
  input  logic [23:0] MemData,
  output logic        InstrValid,
  output logic [23:0] Instr,
  output logic [23:0] InstrPC,
  input  logic        InstrReady,
  input  logic        BranchTaken,
  input  logic [23:0] BranchTarget
);

  localparam int DATA_W = 24;
  // Occupancy at which fetching must pause. Only a depth of 2 is supported.
  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t            state_q, state_d;
  logic              started_q, started_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] ins_q [2];
  logic [DATA_W-1:0] ins_d [2];
  logic [DATA_W-1:0] ipc_q [2];
  logic [DATA_W-1:0] ipc_d [2];
  logic              push, pop;

  // Request is suppressed for the first cycle out of reset, and is dropped
  // while the buffer is full. In DISCARD the squashed read keeps its address.
  assign MemReq     = started_q && (state_q != HOLD);
  assign MemAddr    = pc_q;
  assign InstrValid = (cnt_q != 2'd0);
  assign Instr      = ins_q[0];
  assign InstrPC    = ipc_q[0];

  // A redirect overrides any push or pop in the same cycle.
  assign push = MemReq && MemAck && (state_q == FETCH) && !BranchTaken;
  assign pop  = InstrValid && InstrReady && !BranchTaken;

  // Next-state: buffer push/pop/flush, fetch PC and FSM transitions.
  always_comb begin
    state_d   = state_q;
    started_d = 1'b1;
    pc_d      = pc_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    ins_d     = ins_q;
    ipc_d     = ipc_q;

    // Pop shifts the second entry to the head; a push then lands in the
    // first free slot after the pop.
    if (pop) begin
      ins_d[0] = ins_q[1];
      ipc_d[0] = ipc_q[1];
      cnt_d    = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_d[0]) begin
        ins_d[1] = MemData;
        ipc_d[1] = pc_q;
      end else begin
        ins_d[0] = MemData;
        ipc_d[0] = pc_q;
      end
      cnt_d = cnt_d + 2'd1;
      pc_d  = pc_q + 24'd1;
    end

    case (state_q)
      FETCH: begin
        if (BranchTaken) begin
          if (started_q && !MemAck) begin
            // Read still in flight: hold its address and remember the target.
            target_d = BranchTarget;
            state_d  = DISCARD;
          end else begin
            pc_d = BranchTarget;
          end
        end else if (push && (cnt_d == FULL)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (BranchTaken) begin
          pc_d    = BranchTarget;
          state_d = FETCH;
        end else if (pop) begin
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (MemAck) begin
          pc_d    = BranchTaken ? BranchTarget : target_q;
          state_d = FETCH;
        end else if (BranchTaken) begin
          target_d = BranchTarget;
        end
      end
      default: state_d = FETCH;
    endcase

    if (BranchTaken) cnt_d = 2'd0;
  end

  // State and buffer registers; reset abandons any outstanding read.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= FETCH;
      started_q <= 1'b0;
      pc_q      <= RESET_PC;
      target_q  <= RESET_PC;
      cnt_q     <= 2'd0;
      ins_q     <= '{default: '0};
      ipc_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      pc_q      <= pc_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      ins_q     <= ins_d;
      ipc_q     <= ipc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder with configurable latency, and an
// in-order expected-PC scoreboard for the instruction stream seen by decode.
module tb_fetch_unit;

  localparam logic [23:0] RESET_PC = 24'h000000;
  localparam logic [23:0] DOFS     = 24'h100000;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        MemReq;
  logic [23:0] MemAddr;
  logic        MemAck = 1'b0;
  logic [23:0] MemData = '0;
  logic        InstrValid;
  logic [23:0] Instr;
  logic [23:0] InstrPC;
  logic        InstrReady = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [23:0] BranchTarget = '0;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state
  logic [23:0] exp_pc;
  logic        exp_invalid, prev_hold, prev_wait, last_ack;
  logic [23:0] prev_pc, prev_instr, prev_addr;
  logic        mem_busy;
  int          mem_cnt, mem_lat, fixed_lat, n_deliv;

  always #5 Clock = ~Clock;

  fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
    .Clock(Clock), .Reset(Reset), .MemReq(MemReq), .MemAddr(MemAddr),
    .MemAck(MemAck), .MemData(MemData), .InstrValid(InstrValid),
    .Instr(Instr), .InstrPC(InstrPC), .InstrReady(InstrReady),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget)
  );

  task automatic check_eq(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic init_model();
    exp_pc      = RESET_PC;
    exp_invalid = 1'b0;
    prev_hold   = 1'b0;
    prev_wait   = 1'b0;
    last_ack    = 1'b0;
    mem_busy    = 1'b0;
    mem_cnt     = 0;
  endtask

  // One clock cycle: memory answers, the cycle's handshakes are scored, then
  // the edge is taken and outputs are left settled 1 time unit after it.
  task automatic cycle();
    if (MemReq) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = 0;
        mem_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
      if (mem_cnt == mem_lat) begin
        MemAck   = 1'b1;
        MemData  = MemAddr + DOFS;
        mem_busy = 1'b0;
      end else begin
        MemAck  = 1'b0;
        MemData = 24'($urandom);
        mem_cnt++;
      end
    end else begin
      MemAck   = 1'b0;
      mem_busy = 1'b0;
    end

    if (exp_invalid) check_eq("flush_invalid", InstrValid, 0);
    exp_invalid = 1'b0;
    if (prev_hold) begin
      check_eq("stall_valid", InstrValid, 1);
      check_eq("stall_pc", InstrPC, prev_pc);
      check_eq("stall_instr", Instr, prev_instr);
    end
    if (prev_wait) begin
      check_eq("wait_req", MemReq, 1);
      check_eq("wait_addr", MemAddr, prev_addr);
    end
    if (InstrValid && InstrReady) begin
      check_eq("deliver_pc", InstrPC, exp_pc);
      check_eq("deliver_instr", Instr, exp_pc + DOFS);
      exp_pc = exp_pc + 24'd1;
      n_deliv++;
    end
    if (BranchTaken) begin
      exp_pc      = BranchTarget;
      exp_invalid = 1'b1;
    end
    prev_hold  = InstrValid && !InstrReady && !BranchTaken;
    prev_wait  = MemReq && !MemAck;
    prev_addr  = MemAddr;
    prev_pc    = InstrPC;
    prev_instr = Instr;
    last_ack   = MemReq && MemAck;

    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    BranchTaken = 1'b0;
    MemAck      = 1'b0;
    Reset       = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    init_model();
  endtask

  task automatic wait_ack(input string tag);
    int k = 0;
    while (!last_ack && k < 20) begin cycle(); k++; end
    check_eq(tag, last_ack, 1);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!InstrValid && k < 20) begin cycle(); k++; end
    check_eq(tag, InstrValid, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int d0;
    n_deliv   = 0;
    fixed_lat = 0;
    init_model();

    // Reset values and first request
    repeat (2) @(posedge Clock);
    #1;
    check_eq("rst_memreq", MemReq, 0);
    check_eq("rst_memaddr", MemAddr, RESET_PC);
    check_eq("rst_valid", InstrValid, 0);
    check_eq("rst_instr", Instr, 0);
    check_eq("rst_pc", InstrPC, 0);
    Reset = 1'b1;
    #1;
    check_eq("rel_req_suppressed", MemReq, 0);
    MemAck  = 1'b1;
    MemData = 24'hABCDEF;
    @(posedge Clock); #1;
    MemAck = 1'b0;
    check_eq("first_memreq", MemReq, 1);
    check_eq("first_addr", MemAddr, RESET_PC);
    check_eq("stale_ack_ignored", InstrValid, 0);
    init_model();

    // Zero-wait streaming, one instruction per cycle
    InstrReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check_eq("zw_gapless", InstrValid, 1);
    end

    // Decode stall: buffer fills to 2 and fetch pauses
    InstrReady = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) cycle();
    check_eq("hold_memreq", MemReq, 0);
    check_eq("hold_valid", InstrValid, 1);
    check_eq("hold_pc", InstrPC, 24'h000000);
    InstrReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("resume_gapless", InstrValid, 1);
    end

    // Branch on second wait cycle of a 3-wait read
    fixed_lat = 3;
    do_reset();
    cycle();
    BranchTaken  = 1'b1;
    BranchTarget = 24'h000400;
    cycle();
    BranchTaken = 1'b0;
    wait_ack("discard_ack_seen");
    check_eq("discard_next_req", MemReq, 1);
    check_eq("discard_next_addr", MemAddr, 24'h000400);
    wait_valid("discard_valid");
    check_eq("discard_first_pc", InstrPC, 24'h000400);

    // Second redirect during discard replaces the target
    do_reset();
    cycle();
    BranchTaken  = 1'b1;
    BranchTarget = 24'h000400;
    cycle();
    BranchTarget = 24'h000500;
    cycle();
    BranchTaken = 1'b0;
    wait_ack("retarget_ack_seen");
    check_eq("retarget_addr", MemAddr, 24'h000500);
    wait_valid("retarget_valid");
    check_eq("retarget_first_pc", InstrPC, 24'h000500);

    // Branch coincident with ack: word dropped
    fixed_lat = 1;
    do_reset();
    cycle();
    BranchTaken  = 1'b1;
    BranchTarget = 24'h123456;
    cycle();
    BranchTaken = 1'b0;
    check_eq("coinc_valid", InstrValid, 0);
    check_eq("coinc_req", MemReq, 1);
    check_eq("coinc_addr", MemAddr, 24'h123456);
    wait_valid("coinc_first_valid");
    check_eq("coinc_first_pc", InstrPC, 24'h123456);

    // PC wrap at top of address space
    fixed_lat    = 0;
    BranchTaken  = 1'b1;
    BranchTarget = 24'hFFFFFE;
    cycle();
    BranchTaken = 1'b0;
    wait_valid("wrap_valid");
    check_eq("wrap_pc0", InstrPC, 24'hFFFFFE);
    cycle();
    check_eq("wrap_pc1", InstrPC, 24'hFFFFFF);
    cycle();
    check_eq("wrap_pc2", InstrPC, 24'h000000);
    check_eq("wrap_instr2", Instr, DOFS);

    // Reset pulse while the buffer is full
    InstrReady = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) cycle();
    check_eq("prerst_hold_req", MemReq, 0);
    check_eq("prerst_valid", InstrValid, 1);
    #2 Reset = 1'b0;
    #1;
    check_eq("midrst_valid", InstrValid, 0);
    check_eq("midrst_req", MemReq, 0);
    check_eq("midrst_addr", MemAddr, RESET_PC);
    #3 Reset = 1'b1;
    MemAck  = 1'b1;
    MemData = 24'h5A5A5A;
    @(posedge Clock); #1;
    MemAck = 1'b0;
    check_eq("postrst_valid", InstrValid, 0);
    check_eq("postrst_req", MemReq, 1);
    check_eq("postrst_addr", MemAddr, RESET_PC);
    init_model();
    InstrReady = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // Randomized traffic: latency, backpressure and redirects
    fixed_lat = -1;
    d0 = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      InstrReady  = ($urandom_range(0, 3) != 0);
      BranchTaken = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0)
        BranchTarget = 24'hFFFFFC + 24'($urandom_range(0, 3));
      else
        BranchTarget = 24'($urandom);
      cycle();
      BranchTaken = 1'b0;
    end
    check_eq("random_progress", (n_deliv - d0) > 300, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
